// File: rtl/counter_arst_sclr_pkg.sv
// Shared defaults and types for the modulo-N counter built from d_trig cells.
package counter_arst_sclr_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_MODULUS    = 256;
    localparam int DEF_CLEAR_DATA = 0;

    // Clear polarity used by every d_trig instance in the counter.
    localparam logic CELL_CLEAR_VAL = 1'b1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

endpackage

// File: rtl/counter_arst_sclr_d_trig.sv
// Single-bit D flip-flop with asynchronous clear to a per-instance value DCLR.
module d_trig #(
    parameter logic CLEAR_VAL = 1'b1
) (
    input  logic C,
    input  logic CLR,
    input  logic D,
    input  logic DCLR,
    output logic Q,
    output logic notQ
);

    logic q_q;

    generate
        if (CLEAR_VAL) begin : g_clr_high
            always_ff @(posedge C or posedge CLR) begin
                if (CLR) q_q <= DCLR;
                else     q_q <= D;
            end
        end else begin : g_clr_low
            always_ff @(posedge C or negedge CLR) begin
                if (!CLR) q_q <= DCLR;
                else      q_q <= D;
            end
        end
    endgenerate

    assign Q    = q_q;
    assign notQ = ~q_q;

endmodule

// File: rtl/counter_arst_sclr.sv
// Modulo-N up/down counter with async reset, sync clear, clamped load and a
// registered wrap flag; every state bit lives in a d_trig cell.
module counter_arst_sclr
    import counter_arst_sclr_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int CLEAR_DATA = DEF_CLEAR_DATA
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             SCLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             EN,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_Q};
    localparam logic [WIDTH-1:0] CLR_Q   = WIDTH'(CLEAR_DATA);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    op_e              op;
    logic [WIDTH:0]   din_ext;
    logic [WIDTH-1:0] q_d;
    logic             wrap_d;
    logic             wrap_q;
    logic             wrap_nq;

    always_comb begin
        op = OP_HOLD;
        if (SCLR)          op = OP_CLEAR;
        else if (LOAD)     op = OP_LOAD;
        else if (EN && UP) op = OP_INC;
        else if (EN)       op = OP_DEC;
    end

    // The clamp compare is one bit wider so MODULUS == 2**WIDTH never overflows.
    always_comb begin
        q_d     = Q;
        wrap_d  = 1'b0;
        din_ext = {1'b0, DIN};
        case (op)
            OP_CLEAR: q_d = CLR_Q;
            OP_LOAD:  q_d = (din_ext > MAX_EXT) ? MAX_Q : DIN;
            OP_INC: begin
                wrap_d = (Q == MAX_Q);
                q_d    = (Q == MAX_Q) ? '0 : Q + ONE_Q;
            end
            OP_DEC: begin
                wrap_d = (Q == '0);
                q_d    = (Q == '0) ? MAX_Q : Q - ONE_Q;
            end
            default: q_d = Q;
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            d_trig #(.CLEAR_VAL(CELL_CLEAR_VAL)) u_cell (
                .C    (C),
                .CLR  (CLR),
                .D    (q_d[i]),
                .DCLR (CLR_Q[i]),
                .Q    (Q[i]),
                .notQ (notQ[i])
            );
        end
    endgenerate

    d_trig #(.CLEAR_VAL(CELL_CLEAR_VAL)) u_wrap (
        .C    (C),
        .CLR  (CLR),
        .D    (wrap_d),
        .DCLR (1'b0),
        .Q    (wrap_q),
        .notQ (wrap_nq)
    );

    // Both rails of the flag cell are complementary; combining them keeps WRAP registered.
    assign WRAP = wrap_q & ~wrap_nq;

endmodule

// File: tb/tb_counter_arst_sclr.sv
// Directed bench for counter_arst_sclr: a small-modulus instance and a default instance.
module tb_counter_arst_sclr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_clr = 1'b0, a_sclr = 1'b0, a_load = 1'b0, a_en = 1'b0, a_up = 1'b0;
    logic [3:0] a_din = '0;
    logic [3:0] a_q, a_nq;
    logic       a_wrap;

    logic       b_clr = 1'b0, b_sclr = 1'b0, b_load = 1'b0, b_en = 1'b0, b_up = 1'b0;
    logic [7:0] b_din = '0;
    logic [7:0] b_q, b_nq;
    logic       b_wrap;

    counter_arst_sclr #(.WIDTH(4), .MODULUS(10), .CLEAR_DATA(3)) dut_a (
        .C(clk), .CLR(a_clr), .SCLR(a_sclr), .LOAD(a_load), .DIN(a_din),
        .EN(a_en), .UP(a_up), .Q(a_q), .notQ(a_nq), .WRAP(a_wrap)
    );

    counter_arst_sclr dut_b (
        .C(clk), .CLR(b_clr), .SCLR(b_sclr), .LOAD(b_load), .DIN(b_din),
        .EN(b_en), .UP(b_up), .Q(b_q), .notQ(b_nq), .WRAP(b_wrap)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Counter behaviour expressed as modular arithmetic on integers.
    function automatic void model_step(input int q, input int m, input int cd,
                                       input bit sclr, input bit load, input bit en,
                                       input bit up, input int din,
                                       output int nq, output bit nw);
        nq = q;
        nw = 1'b0;
        if (sclr)      nq = cd;
        else if (load) nq = (din > m - 1) ? m - 1 : din;
        else if (en) begin
            if (up) begin
                nw = (q == m - 1);
                nq = (q + 1) % m;
            end else begin
                nw = (q == 0);
                nq = (q + m - 1) % m;
            end
        end
    endfunction

    int ma_q = 0, mb_q = 0;
    bit ma_w = 1'b0, mb_w = 1'b0;

    always @(posedge clk or posedge a_clr) begin : model_a
        int nq;
        bit nw;
        if (a_clr) begin
            ma_q <= 3;
            ma_w <= 1'b0;
        end else begin
            model_step(ma_q, 10, 3, a_sclr, a_load, a_en, a_up, int'(a_din), nq, nw);
            ma_q <= nq;
            ma_w <= nw;
        end
    end

    always @(posedge clk or posedge b_clr) begin : model_b
        int nq;
        bit nw;
        if (b_clr) begin
            mb_q <= 0;
            mb_w <= 1'b0;
        end else begin
            model_step(mb_q, 256, 0, b_sclr, b_load, b_en, b_up, int'(b_din), nq, nw);
            mb_q <= nq;
            mb_w <= nw;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("A.Q",    32'(a_q),    32'(ma_q));
            check("A.notQ", 32'(a_nq),   32'(~ma_q) & 32'hF);
            check("A.WRAP", 32'(a_wrap), 32'(ma_w));
            check("B.Q",    32'(b_q),    32'(mb_q));
            check("B.notQ", 32'(b_nq),   32'(~mb_q) & 32'hFF);
            check("B.WRAP", 32'(b_wrap), 32'(mb_w));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int up_seq [7] = '{4, 5, 6, 7, 8, 9, 0};

    initial begin
        #1;
        a_clr = 1'b1;
        b_clr = 1'b1;
        step();
        a_clr = 1'b0;
        b_clr = 1'b0;
        cmp_on = 1'b1;
        check("A.reset_q",    32'(a_q),    32'd3);
        check("A.reset_notq", 32'(a_nq),   32'hC);
        check("A.reset_wrap", 32'(a_wrap), 32'd0);
        check("B.reset_q",    32'(b_q),    32'd0);
        check("B.reset_notq", 32'(b_nq),   32'hFF);

        a_en = 1'b1;
        a_up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("A.up_q",    32'(a_q),    32'(up_seq[i]));
            check("A.up_wrap", 32'(a_wrap), (i == 6) ? 32'd1 : 32'd0);
        end

        a_up = 1'b0;
        step();
        check("A.down_wrap_q",    32'(a_q),    32'd9);
        check("A.down_wrap_flag", 32'(a_wrap), 32'd1);
        step();
        check("A.down_q",    32'(a_q),    32'd8);
        check("A.down_flag", 32'(a_wrap), 32'd0);

        a_load = 1'b1;
        a_din  = 4'd15;
        a_up   = 1'b1;
        step();
        check("A.load_clamp_q",    32'(a_q),    32'd9);
        check("A.load_clamp_wrap", 32'(a_wrap), 32'd0);
        a_sclr = 1'b1;
        a_din  = 4'd5;
        step();
        check("A.sclr_wins_q", 32'(a_q), 32'd3);
        a_sclr = 1'b0;
        a_din  = 4'd10;
        step();
        check("A.load_modulus_q", 32'(a_q), 32'd9);
        a_din = 4'd7;
        step();
        check("A.load_7_q", 32'(a_q), 32'd7);

        a_load = 1'b0;
        a_en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_up = ~a_up;
            step();
            check("A.hold_q",    32'(a_q),    32'd7);
            check("A.hold_wrap", 32'(a_wrap), 32'd0);
        end

        #2;
        a_clr = 1'b1;
        #1;
        check("A.async_q",    32'(a_q),    32'd3);
        check("A.async_notq", 32'(a_nq),   32'hC);
        check("A.async_wrap", 32'(a_wrap), 32'd0);
        a_clr = 1'b0;
        a_en  = 1'b1;
        a_up  = 1'b0;
        step();
        check("A.after_clr_q", 32'(a_q), 32'd2);
        a_en = 1'b0;

        b_load = 1'b1;
        b_din  = 8'd255;
        step();
        check("B.load_q", 32'(b_q), 32'd255);
        b_load = 1'b0;
        b_en   = 1'b1;
        b_up   = 1'b1;
        step();
        check("B.wrap_q",    32'(b_q),    32'd0);
        check("B.wrap_flag", 32'(b_wrap), 32'd1);
        #2;
        b_clr = 1'b1;
        b_en  = 1'b0;
        #1;
        check("B.async_wrap", 32'(b_wrap), 32'd0);
        check("B.async_q",    32'(b_q),    32'd0);
        step();
        check("B.held_clr_q", 32'(b_q), 32'd0);
        b_clr = 1'b0;
        b_en  = 1'b1;
        b_up  = 1'b0;
        step();
        check("B.down_wrap_q",    32'(b_q),    32'd255);
        check("B.down_wrap_flag", 32'(b_wrap), 32'd1);
        b_en = 1'b0;
        step();
        check("B.idle_q",    32'(b_q),    32'd255);
        check("B.idle_wrap", 32'(b_wrap), 32'd0);

        step();
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_arst_sclr.md
Name: counter_arst_sclr

Overview:
- Parameterisable modulo-N up/down counter built from WIDTH instances of the d_trig bit cell. It is the consumer of that cell in the counter_async_reset_n_clear_input project.
- Provides asynchronous reset, synchronous clear, parallel load, count enable and a registered wrap flag.
- Feeds downstream timing/compare logic with Q, notQ and WRAP.

Parameters:
- WIDTH, 8, counter width in bits; legal range is at least 2.
- MODULUS, 256, count range 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
- CLEAR_DATA, 0, value forced by CLR and by SCLR; must be < MODULUS.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- CLR  input  1  asynchronous reset, active-high.
- SCLR  input  1  synchronous clear, active-high.
- LOAD  input  1  synchronous parallel load, active-high.
- DIN  input  WIDTH  load value.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- Q  output  WIDTH  counter value.
- notQ  output  WIDTH  bitwise inverse of Q, taken from the cells' notQ.
- WRAP  output  1  registered wrap flag.

Behaviour:
- Reset (CLR=1, asynchronous, no clock needed):
  - Q=CLEAR_DATA, notQ=~CLEAR_DATA, WRAP=0, immediately.
  - Reset is held for as long as CLR=1.
  - On CLR deassert, the first rising edge of C is evaluated normally.
- Synchronous priority at each rising edge, highest first:
  1. SCLR → Q<=CLEAR_DATA, WRAP<=0.
  2. LOAD → Q<=min(DIN, MODULUS-1), WRAP<=0.
  3. EN&UP → Q<=(Q==MODULUS-1) ? 0 : Q+1.
  4. EN&!UP → Q<=(Q==0) ? MODULUS-1 : Q-1.
  5. else → Q holds, WRAP<=0.
- WRAP:
  - Registered; high for exactly one cycle after an edge where EN counted across the boundary (MODULUS-1→0 up, 0→MODULUS-1 down).
  - Cleared on any other edge, including an edge where SCLR or LOAD wins.
- Latency: one clock from input sampling to Q/WRAP; no combinational path from inputs to outputs.
- Arithmetic: unsigned, computed at WIDTH+1 bits internally to avoid overflow on the DIN clamp; no signed interpretation.
- Non-power-of-two MODULUS:
  - Q never exceeds MODULUS-1 except via reset, which is legal by the CLEAR_DATA constraint.
  - A LOAD of DIN >= MODULUS clamps to MODULUS-1.
- Simultaneous events: SCLR+LOAD+EN → SCLR wins. LOAD+EN → load wins; no count that cycle.
- UP may change every cycle; direction is sampled only on the counting edge.
- Reset mid-operation: CLR asserted between edges forces outputs within the same delta. A pending WRAP is cleared.
- Structure:
  - Each bit is a d_trig with CLEAR_VAL=1 and CLR wired directly.
  - DCLR of bit i = CLEAR_DATA[i].
  - D of bit i = next-state bit i.
  - WRAP uses one additional d_trig with DCLR=0.

Decomposition:
- Shared constants include (counter_defs.vh): default WIDTH, MODULUS, CLEAR_DATA, and the CLEAR_VAL polarity constant (1) used for every d_trig instance.
- One natural sub-module: the existing d_trig cell, instantiated WIDTH+1 times.
- Next-state mux and wrap detection stay as combinational logic in counter_arst_sclr; no further sub-modules.

Test Plan:
- WIDTH=4, MODULUS=10, CLEAR_DATA=3; pulse CLR=1 mid-cycle → Q=3, notQ=4'hC, WRAP=0 before the next edge.
- After reset, EN=1, UP=1 for 7 edges → Q sequence 4,5,6,7,8,9,0; WRAP=1 only in the cycle after Q becomes 0, then 0 again.
- Q=0, EN=1, UP=0, one edge → Q=9, WRAP=1 for one cycle. Next edge → Q=8, WRAP=0.
- LOAD=1, DIN=15, EN=1 → Q=9, no count, WRAP=0. Then LOAD=1, DIN=5 with SCLR=1 → Q=3.
- EN=0 for 5 edges with UP toggling every cycle → Q stable at its value, WRAP=0 throughout.
- Defaults (WIDTH=8, MODULUS=256, CLEAR_DATA=0): load 255, count up → Q=0, WRAP=1. Assert CLR during the WRAP cycle → WRAP=0 and Q=0 asynchronously.
